// File: rtl/dsp48_preadder_sched_if.sv
// dsp48_preadder_sched_if: request, D-fetch and result signals of the pre-adder scheduler
interface dsp48_preadder_sched_if #(parameter int TAG_W = 4);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic             op_a1;
  logic [TAG_W-1:0] op_tag;
  logic             flush;
  logic             d_take;
  logic [TAG_W-1:0] d_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             op_err;
  modport master (
    output op_valid, op_code, op_a1, op_tag, flush,
    input  op_ready, d_take, d_tag, res_valid, res_tag, op_err
  );
  modport slave (
    input  op_valid, op_code, op_a1, op_tag, flush,
    output op_ready, d_take, d_tag, res_valid, res_tag, op_err
  );
endinterface

// File: rtl/dsp48_preadder_sched.sv
// dsp48_preadder_sched: issue scheduler driving INMODE, clock enables and resets of a DSP48E1 A/D pre-adder
module dsp48_preadder_sched #(
  parameter int    AREG      = 2,
  parameter int    DREG      = 1,
  parameter int    ADREG     = 1,
  parameter string USE_DPORT = "TRUE",
  parameter int    TAG_W     = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  dsp48_preadder_sched_if.slave bus,
  output logic [3:0]            INMODE,
  output logic                  CEA1,
  output logic                  CEA2,
  output logic                  CED,
  output logic                  CEAD,
  output logic                  RSTA,
  output logic                  RSTD
);
  localparam bit DP   = USE_DPORT == "TRUE";
  localparam int AD   = DP ? ADREG : 0;
  localparam int DOFF = DP ? DREG : 0;
  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;
  typedef struct packed {
    logic             v;
    logic             d;
    logic [3:0]       im;
    logic [TAG_W-1:0] tag;
  } slot_t;
  state_t     state, state_nx;
  slot_t      slot_q [4];
  slot_t      eff [4];
  slot_t      new_s, res_q, res_now;
  logic [2:0] c;
  logic [1:0] la, lp;
  logic       illegal, run, take, err_q;
  // decode the request: cycles until its data reaches the pre-adder, its INMODE image, its legality
  always_comb begin
    c = bus.op_code;
    la = (AREG == 2 && bus.op_a1) ? 2'd1 : 2'(AREG);
    lp = (DP && 2'(DREG) > la) ? 2'(DREG) : la;
    illegal = c[2:1] == 2'b11 || (!DP && c inside {[3'd1:3'd4]});
    new_s = {1'b1, c inside {[3'd2:3'd4]}, c == 3'd1 || c == 3'd3, c inside {[3'd2:3'd4]}, c[2],
             AREG == 2 && bus.op_a1, bus.op_tag};
    run = state == RUN && !bus.flush;
    bus.op_ready = run && (illegal || !slot_q[lp].v);
    take = bus.op_valid && bus.op_ready && !illegal;
  end
  // slot k holds the op reaching the pre-adder k cycles from now, with this cycle's issue merged in
  always_comb begin
    for (int i = 0; i < 4; i++) eff[i] = slot_q[i].v ? slot_q[i] : (take && lp == 2'(i)) ? new_s : '0;
    res_now = AD == 1 ? res_q : eff[0];
    INMODE = run ? eff[0].im : 4'd0;
    bus.d_take = run && DP && eff[DOFF].d;
    bus.d_tag = bus.d_take ? eff[DOFF].tag : '0;
    bus.res_valid = run && res_now.v;
    bus.res_tag = bus.res_valid ? res_now.tag : '0;
    bus.op_err = err_q;
  end
  // advance the slot view one cycle; a flush or a non-RUN state drops everything in flight
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) slot_q[i] <= run ? eff[i+1] : '0;
      slot_q[3] <= '0;
      res_q <= run ? eff[0] : '0;
      err_q <= bus.op_valid && bus.op_ready && illegal;
    end
  // state register
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) state <= INIT;
    else state <= state_nx;
  // INIT and FLUSH last one cycle with the slice input registers held in reset and clocks stopped
  always_comb begin
    state_nx = bus.flush ? FLUSH : RUN;
    RSTA = state != RUN;
    RSTD = state != RUN;
    {CEA1, CEA2, CED, CEAD} = {4{state == RUN}};
  end
endmodule

// File: tb/tb_dsp48_preadder_sched.sv
// tb_dsp48_preadder_sched: scoreboard bench over three slice configurations
module tb_dsp48_preadder_sched;
  typedef struct {int k; int g; int cyc; int val;} ev_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         errs = 0;
  int         checks = 0;
  ev_t        q[$];
  string      nm[4] = '{"res", "d_take", "inmode", "op_err"};
  logic       vld[3], a1[3], fl[3];
  logic [2:0] code[3];
  logic [3:0] tag[3];
  logic       rdy[3], rv[3], dt[3], oe[3], rsta[3], rstd[3];
  logic [3:0] rt[3], dtg[3], im[3], ce[3];
  logic       mp;
  int         mv, mh;
  dsp48_preadder_sched_if #(.TAG_W(4)) b[3] ();
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  for (genvar g = 0; g < 3; g++) begin : gi
    dsp48_preadder_sched #(
      .AREG(g == 2 ? 0 : 2), .DREG(1), .ADREG(g == 2 ? 0 : 1),
      .USE_DPORT(g == 1 ? "FALSE" : "TRUE"), .TAG_W(4)
    ) dut (
      .CLK(clk), .RSTN(rst_n), .bus(b[g]), .INMODE(im[g]),
      .CEA1(ce[g][3]), .CEA2(ce[g][2]), .CED(ce[g][1]), .CEAD(ce[g][0]),
      .RSTA(rsta[g]), .RSTD(rstd[g])
    );
    assign b[g].op_valid = vld[g];
    assign b[g].op_code = code[g];
    assign b[g].op_a1 = a1[g];
    assign b[g].op_tag = tag[g];
    assign b[g].flush = fl[g];
    assign rdy[g] = b[g].op_ready;
    assign rv[g] = b[g].res_valid;
    assign rt[g] = b[g].res_tag;
    assign dt[g] = b[g].d_take;
    assign dtg[g] = b[g].d_tag;
    assign oe[g] = b[g].op_err;
  end
  function automatic void expect_ev(input int k, input int g, input int cy, input int v);
    ev_t e;
    e.k = k; e.g = g; e.cyc = cy; e.val = v;
    q.push_back(e);
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", n, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // drive one request until accepted; expectations are hand-supplied offsets from the accept cycle
  task automatic issue(input int g, input int c, input bit a, input int t, input int lp, input int ime,
                       input int doff, input int l, input bit ill, output int acc);
    vld[g] = 1'b1; code[g] = 3'(c); a1[g] = a; tag[g] = 4'(t);
    acc = -1;
    for (int n = 0; n < 8 && acc < 0; n++) begin
      #1;
      if (rdy[g]) begin
        acc = cyc;
        if (ill) expect_ev(3, g, acc + 1, 1);
        else begin
          if (ime != 0) expect_ev(2, g, acc + lp, ime);
          if (doff >= 0) expect_ev(1, g, acc + doff, t);
          expect_ev(0, g, acc + l, t);
        end
      end
      @(posedge clk);
      #1;
    end
    vld[g] = 1'b0;
    checks++;
    if (acc < 0) begin
      errs++;
      $display("FAIL accept dut%0d tag %0d: op_ready never seen within 8 cycles", g, t);
    end
  endtask
  // monitor: every observed output must match a queued expectation for this exact cycle
  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++) begin
        mp = k == 0 ? rv[g] : k == 1 ? dt[g] : k == 2 ? im[g] != 4'd0 : oe[g];
        mv = k == 0 ? int'(rt[g]) : k == 1 ? int'(dtg[g]) : k == 2 ? int'(im[g]) : 1;
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].k == k && q[i].g == g && q[i].cyc < cyc) begin
            checks++;
            errs++;
            $display("FAIL missed %s dut%0d: expected %0d at cycle %0d, not observed", nm[k], g, q[i].val, q[i].cyc);
            q.delete(i);
          end
        if (mp) begin
          mh = -1;
          foreach (q[i]) if (mh < 0 && q[i].k == k && q[i].g == g && q[i].cyc == cyc) mh = i;
          checks++;
          if (mh < 0 || q[mh].val != mv) begin
            errs++;
            $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm[k], g, cyc, mv, mh < 0 ? -1 : q[mh].val);
          end
          if (mh >= 0) q.delete(mh);
        end
      end
  initial begin
    int t0, t1, t2, t3;
    for (int g = 0; g < 3; g++) begin
      vld[g] = 1'b0; code[g] = 3'd0; a1[g] = 1'b0; tag[g] = 4'd0; fl[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset dut%0d", g), int'({im[g], ce[g], rsta[g], rstd[g], rdy[g], rv[g], dt[g], oe[g], rt[g], dtg[g]}), 'h3000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("init dut%0d rsta/rstd/ready", g), int'({rsta[g], rstd[g], rdy[g]}), 'b110);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("run dut%0d rsta/rstd/ready/ce", g), int'({rsta[g], rstd[g], rdy[g], ce[g]}), 'b0011111);
    @(posedge clk);
    #1;
    // defaults: D_PLUS_A A2 -> d_take t+1, INMODE 0100 t+2, result t+3
    issue(0, 2, 0, 5, 2, 'b0100, 1, 3, 0, t0);
    idle(4);
    // A1 op right behind an A2 op stalls one cycle
    issue(0, 0, 0, 1, 2, 0, -1, 3, 0, t0);
    issue(0, 0, 1, 2, 1, 'b0001, -1, 2, 0, t1);
    chk("A1 after A2 accept cycle", t1, t0 + 2);
    idle(4);
    // equal-latency ops at full throughput
    issue(0, 1, 0, 6, 2, 'b1000, -1, 3, 0, t0);
    issue(0, 3, 0, 7, 2, 'b1100, 1, 3, 0, t1);
    issue(0, 4, 0, 3, 2, 'b0110, 1, 3, 0, t1);
    issue(0, 5, 0, 4, 2, 'b0010, -1, 3, 0, t1);
    chk("four A2 ops back to back", t1 - t0, 3);
    issue(0, 2, 1, 9, 1, 'b0101, 0, 2, 0, t0);
    issue(0, 0, 1, 10, 1, 'b0001, -1, 2, 0, t1);
    issue(0, 0, 0, 11, 2, 0, -1, 3, 0, t2);
    chk("A2 after A1 no stall", t2 - t1, 1);
    // illegal codes are consumed at once and flagged
    issue(0, 6, 0, 12, 0, 0, -1, 0, 1, t0);
    issue(0, 7, 0, 12, 0, 0, -1, 0, 1, t1);
    chk("illegal ops back to back", t1 - t0, 1);
    idle(4);
    // flush with three ops in flight and a competing request
    issue(0, 2, 0, 13, 2, 'b0100, 1, 3, 0, t0);
    issue(0, 2, 0, 14, 2, 'b0100, 1, 3, 0, t1);
    issue(0, 2, 0, 15, 2, 'b0100, 1, 3, 0, t1);
    fl[0] = 1'b1; vld[0] = 1'b1; code[0] = 3'd0; a1[0] = 1'b0; tag[0] = 4'd0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].g == 0 && q[i].k < 3 && q[i].cyc >= cyc) q.delete(i);
    @(negedge clk);
    chk("flush beats op_valid", int'(rdy[0]), 0);
    @(posedge clk);
    #1;
    fl[0] = 1'b0; vld[0] = 1'b0;
    @(negedge clk);
    chk("flush state rsta/rstd/ready", int'({rsta[0], rstd[0], rdy[0]}), 'b110);
    @(negedge clk);
    chk("run after flush rsta/ready/ce", int'({rsta[0], rdy[0], ce[0]}), 'b011111);
    @(posedge clk);
    #1;
    issue(0, 0, 0, 8, 2, 0, -1, 3, 0, t0);
    idle(4);
    // no D port: D ops illegal, L = LA
    issue(1, 2, 0, 10, 0, 0, -1, 0, 1, t0);
    issue(1, 0, 0, 11, 2, 0, -1, 2, 0, t1);
    chk("no-dport PASS_A after illegal", t1 - t0, 1);
    issue(1, 1, 0, 12, 0, 0, -1, 0, 1, t2);
    issue(1, 5, 1, 13, 1, 'b0011, -1, 1, 0, t3);
    chk("no-dport ZERO A1 accept", t3 - t2, 1);
    idle(4);
    // AREG=0, ADREG=0: PASS_D d_take at t, INMODE and result at t+1
    issue(2, 4, 0, 3, 1, 'b0110, 0, 1, 0, t0);
    issue(2, 0, 1, 4, 1, 0, -1, 1, 0, t1);
    issue(2, 5, 0, 5, 1, 'b0010, -1, 1, 0, t2);
    chk("AREG0 back to back", t2 - t0, 2);
    idle(8);
    chk("scoreboard drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
